serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx_pkg.sv | 31 +++
 rtl/serial_frame_tx_bit_timer.sv | 42 ++++
 rtl/serial_frame_tx.sv | 140 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding and
// elaboration-time helpers.
package serial_frame_tx_pkg;

  localparam int MAX_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Ceiling log2 with a floor of 1 so single-value counters still get a bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Per-bit cycle counter: runs 0..BIT_CYCLES-1 and flags the last cycle of a bit.
module serial_frame_tx_bit_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int TW         = clog2_min1(BIT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic          tick,
  output logic [TW-1:0] count
);

  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  assign tick  = (count_q == LAST);
  assign count = count_q;

  // next count: wrap on the last cycle of a bit or when the FSM holds it idle
  always_comb begin
    count_d = count_q;
    if (clear || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + TW'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W bits LSB first,
// optional even parity, stop bit; every bit held BIT_CYCLES clocks.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sd,
  output logic              busy,
  output logic              done
);

  localparam int TW = clog2_min1(BIT_CYCLES);
  localparam int IW = clog2_min1(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic [TW-1:0] PRE_LAST = TW'((BIT_CYCLES >= 2) ? (BIT_CYCLES - 2) : 0);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IW-1:0]     idx_q;
  logic              par_q;
  logic              sd_q;
  logic              busy_q;
  logic              done_q;

  logic              tick_s;
  logic [TW-1:0]     cnt_s;
  logic [DATA_W-1:0] shift_nx_s;
  logic              last_bit_s;
  logic              stop_entry_s;
  logic              done_d;

  serial_frame_tx_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .TW         (TW)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == IDLE),
    .tick  (tick_s),
    .count (cnt_s)
  );

  assign shift_nx_s   = shift_q >> 1;
  assign last_bit_s   = (idx_q == LAST_IDX);
  assign stop_entry_s = tick_s && (((state_q == DATA) && last_bit_s && (PARITY_EN == 0))
                                   || (state_q == PARITY));

  // done is registered, so it is raised one edge ahead of the final stop cycle
  always_comb begin
    done_d = 1'b0;
    if (BIT_CYCLES == 1) begin
      done_d = stop_entry_s;
    end else begin
      done_d = (state_q == STOP) && (cnt_s == PRE_LAST);
    end
  end

  // frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      sd_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            state_q <= START;
            shift_q <= tx_data;
            par_q   <= even_parity(MAX_DATA_W'(tx_data));
            idx_q   <= '0;
            sd_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            state_q <= DATA;
            sd_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (tick_s) begin
            if (last_bit_s) begin
              idx_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                sd_q    <= par_q;
              end else begin
                state_q <= STOP;
                sd_q    <= 1'b1;
              end
            end else begin
              shift_q <= shift_nx_s;
              idx_q   <= idx_q + IW'(1);
              sd_q    <= shift_nx_s[0];
            end
          end
        end
        PARITY: begin
          if (tick_s) begin
            state_q <= STOP;
            sd_q    <= 1'b1;
          end
        end
        STOP: begin
          if (tick_s) begin
            state_q <= IDLE;
            sd_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          sd_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign sd       = sd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench: three configurations of serial_frame_tx driven with
// directed and random frames, compared against a bit-sequence reference model.
module tb_serial_frame_tx;

  logic clk;
  logic rst;

  logic       v0, v1, v2;
  logic [7:0] d0, d1;
  logic [3:0] d2;
  logic       rdy0, rdy1, rdy2;
  logic       sd0, sd1, sd2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int checks = 0;
  int errors = 0;

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(0)) u0 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
    .sd(sd0), .busy(busy0), .done(done0));

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
    .sd(sd1), .busy(busy1), .done(done1));

  serial_frame_tx #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_EN(0)) u2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(rdy2),
    .sd(sd2), .busy(busy2), .done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cfg(input int w, output int dw, output int bc, output int pe);
    case (w)
      0:       begin dw = 8; bc = 4; pe = 0; end
      1:       begin dw = 8; bc = 4; pe = 1; end
      default: begin dw = 4; bc = 1; pe = 0; end
    endcase
  endtask

  task automatic set_in(input int w, input logic v, input logic [15:0] d);
    case (w)
      0:       begin v0 = v; d0 = d[7:0]; end
      1:       begin v1 = v; d1 = d[7:0]; end
      default: begin v2 = v; d2 = d[3:0]; end
    endcase
  endtask

  // {sd, busy, done, tx_ready}
  function automatic logic [3:0] obs(input int w);
    case (w)
      0:       return {sd0, busy0, done0, rdy0};
      1:       return {sd1, busy1, done1, rdy1};
      default: return {sd2, busy2, done2, rdy2};
    endcase
  endfunction

  // Reference: the frame is a list of bits, each held bc cycles; cycle k >= 1.
  function automatic logic exp_sd(input logic [15:0] d, input int dw, input int bc,
                                  input int pe, input int k);
    int b;
    int ones;
    b = (k - 1) / bc;
    ones = 0;
    for (int i = 0; i < dw; i++) ones += int'(d[i]);
    if (b == 0) return 1'b0;
    if (b <= dw) return d[b-1];
    if (pe != 0 && b == dw + 1) return 1'(ones % 2);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int w, input int k,
                     input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s dut=%0d cycle=%0d got=%b exp=%b", tag, w, k, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int w, input int k);
    logic [3:0] o;
    o = obs(w);
    chk({tag, "_sd"}, w, k, o[3], 1'b1);
    chk({tag, "_busy"}, w, k, o[2], 1'b0);
    chk({tag, "_done"}, w, k, o[1], 1'b0);
    chk({tag, "_rdy"}, w, k, o[0], 1'b1);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle F+1.
  task automatic frame(input int w, input logic [15:0] d, input bit hold, input bit scramble);
    int dw, bc, pe, f;
    logic [3:0] o;
    cfg(w, dw, bc, pe);
    f = (dw + 2 + pe) * bc;
    o = obs(w);
    chk("rdy_pre", w, 0, o[0], 1'b1);
    set_in(w, 1'b1, d);
    for (int k = 1; k <= f + 1; k++) begin
      @(negedge clk);
      o = obs(w);
      if (k <= f) begin
        chk("sd", w, k, o[3], exp_sd(d, dw, bc, pe, k));
      end else begin
        chk("sd_gap", w, k, o[3], 1'b1);
      end
      chk("busy", w, k, o[2], (k <= f) ? 1'b1 : 1'b0);
      chk("done", w, k, o[1], (k == f) ? 1'b1 : 1'b0);
      chk("rdy", w, k, o[0], (k == f + 1) ? 1'b1 : 1'b0);
      if (k <= f) begin
        if (scramble) begin
          set_in(w, hold, 16'($urandom));
        end else if (k == 1 && !hold) begin
          set_in(w, 1'b0, d);
        end
      end
    end
  endtask

  initial begin
    logic [3:0] o;
    rst = 1'b1;
    set_in(0, 1'b1, 16'($urandom));
    set_in(1, 1'b1, 16'($urandom));
    set_in(2, 1'b1, 16'($urandom));

    // reset held with tx_valid high: nothing may be accepted
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      for (int w = 0; w < 3; w++) chk_idle("rst", w, c);
    end
    rst = 1'b0;
    for (int w = 0; w < 3; w++) set_in(w, 1'b0, 16'h0000);
    @(negedge clk);
    for (int w = 0; w < 3; w++) chk_idle("post_rst", w, 0);

    // idle with tx_valid low stays put
    repeat (2) @(negedge clk);
    chk_idle("idle", 0, 0);

    // defaults, A5
    frame(0, 16'h00A5, 1'b0, 1'b0);
    @(negedge clk);
    chk_idle("after_a5", 0, 0);

    // parity configuration: A5 -> parity 0, 07 -> parity 1
    frame(1, 16'h00A5, 1'b0, 1'b0);
    frame(1, 16'h0007, 1'b0, 1'b0);

    // back-to-back with tx_valid held high
    frame(0, 16'h003C, 1'b1, 1'b0);
    frame(0, 16'h00C3, 1'b0, 1'b0);

    // reset in cycle 15 of an FF frame
    set_in(0, 1'b1, 16'h00FF);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      o = obs(0);
      chk("mid_sd", 0, k, o[3], exp_sd(16'h00FF, 8, 4, 0, k));
      if (k == 1) set_in(0, 1'b0, 16'h00FF);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("mid_rst", 0, 16);
    for (int k = 17; k <= 50; k++) begin
      @(negedge clk);
      o = obs(0);
      chk("abandon_done", 0, k, o[1], 1'b0);
      chk("abandon_sd", 0, k, o[3], 1'b1);
    end
    frame(0, 16'h0001, 1'b0, 1'b0);

    // single-cycle bits, data changed after accept
    frame(2, 16'h0009, 1'b0, 1'b1);

    // random traffic on every configuration
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 3; w++) begin
        bit hold;
        bit scr;
        hold = 1'($urandom % 2);
        scr  = 1'($urandom % 2);
        frame(w, 16'($urandom), hold, scr);
        if (hold) begin
          frame(w, 16'($urandom), 1'b0, scr);
        end
        set_in(w, 1'b0, 16'h0000);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
